// File: rtl/display_scan_driver_pkg.sv
// Shared definitions for the multiplexed 4-digit 7-segment scan driver.
// Holds the scan state enum, the digit count and the segment glyphs.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high.
package display_scan_driver_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0    = 7'b0111111;
  localparam logic [6:0] GLYPH_1    = 7'b0000110;
  localparam logic [6:0] GLYPH_2    = 7'b1011011;
  localparam logic [6:0] GLYPH_3    = 7'b1001111;
  localparam logic [6:0] GLYPH_4    = 7'b1100110;
  localparam logic [6:0] GLYPH_5    = 7'b1101101;
  localparam logic [6:0] GLYPH_6    = 7'b1111101;
  localparam logic [6:0] GLYPH_7    = 7'b0000111;
  localparam logic [6:0] GLYPH_8    = 7'b1111111;
  localparam logic [6:0] GLYPH_9    = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

endpackage

// File: rtl/display_scan_driver_if.sv
// Bus between the BCD counter side and the display scan driver.
//   value_i    : four BCD digits, digit0 in [3:0]
//   load_i     : one-cycle strobe capturing value_i / dp_i
//   dp_i       : decimal-point request, bit n = digit n
//   lz_blank_i : level, 1 = suppress leading zeros
//   seg_o      : segments {g,f,e,d,c,b,a}, active-high, registered
//   dp_o       : decimal-point segment, registered
//   dig_o      : one-hot (or zero) digit enable, registered
//   frame_o    : one-cycle pulse in the first blank cycle of digit 0
//   scan_state : current scan state (BLANK/SHOW) for observation
// Handshake: load_i has no back-pressure; every cycle with load_i high
// is a transfer, and the driver always accepts it.
// master = data source / observer, slave = the scan driver.
interface display_scan_driver_if;
  import display_scan_driver_pkg::*;

  logic [15:0] value_i;
  logic        load_i;
  logic [3:0]  dp_i;
  logic        lz_blank_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  dig_o;
  logic        frame_o;
  scan_state_e scan_state;

  modport master (
    output value_i, load_i, dp_i, lz_blank_i,
    input  seg_o, dp_o, dig_o, frame_o, scan_state
  );

  modport slave (
    input  value_i, load_i, dp_i, lz_blank_i,
    output seg_o, dp_o, dig_o, frame_o, scan_state
  );

endinterface

// File: rtl/display_scan_driver_seg7_decode.sv
// Combinational BCD to 7-segment decoder.
//   code : 4-bit BCD digit
//   seg  : segments {g,f,e,d,c,b,a}; codes A-F show a dash
module seg7_decode
  import display_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_DASH;
    case (code)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed driver for a 4-digit 7-segment display.
// Each digit slot lasts SCAN_DIV cycles; the first BLANK_CYC cycles of a
// slot drive everything dark (ghosting guard), the rest show the digit.
// New data is double-buffered and only swapped in at the frame boundary
// (digit 3 -> digit 0 wrap), so a frame never shows mixed values.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of display_scan_driver_if (data in, display out)
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  display_scan_driver_if.slave  bus
);

  if (SCAN_DIV < 4 || SCAN_DIV > 65535) begin : g_bad_scan_div
    $error("display_scan_driver: SCAN_DIV out of range 4..65535");
  end
  if (BLANK_CYC < 1 || BLANK_CYC > SCAN_DIV - 2) begin : g_bad_blank_cyc
    $error("display_scan_driver: BLANK_CYC out of range 1..SCAN_DIV-2");
  end

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  scan_state_e   state_q, state_d;

  logic [15:0]   active_val, shadow_val;
  logic [3:0]    active_dp, shadow_dp;
  logic          pending;

  logic          slot_wrap;
  logic          frame_wrap;
  logic [3:0]    cur_code;
  logic [6:0]    cur_glyph;
  logic          cur_blank;

  assign slot_wrap  = (cnt_q == CNT_MAX);
  assign frame_wrap = slot_wrap && (digit_q == 2'd3);

  // Next-state logic: the state tracks where the counter will be, so the
  // state register and the counter always agree.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    state_d = SHOW;
    if (slot_wrap) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end
    if (cnt_d < BLANK_END) begin
      state_d = BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
      state_q <= BLANK;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      state_q <= state_d;
    end
  end

  // Double buffer. A load landing exactly on the frame boundary bypasses
  // the shadow so it is not delayed by a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_val <= '0;
      active_dp  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else if (frame_wrap) begin
      pending <= 1'b0;
      if (bus.load_i) begin
        active_val <= bus.value_i;
        active_dp  <= bus.dp_i;
        shadow_val <= bus.value_i;
        shadow_dp  <= bus.dp_i;
      end else if (pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
    end else if (bus.load_i) begin
      shadow_val <= bus.value_i;
      shadow_dp  <= bus.dp_i;
      pending    <= 1'b1;
    end
  end

  assign cur_code = active_val[{digit_q, 2'b00} +: 4];

  // Leading zero: this digit and all above it are zero, i.e. the value
  // shifted down to this digit is zero. Digit 0 always shows.
  assign cur_blank = bus.lz_blank_i && (digit_q != 2'd0) &&
                     ((active_val >> {digit_q, 2'b00}) == 16'd0);

  seg7_decode u_seg7_decode (
    .code (cur_code),
    .seg  (cur_glyph)
  );

  // Output register: everything seen on the pins is one cycle behind the
  // counter/digit state that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg_o   <= '0;
      bus.dp_o    <= 1'b0;
      bus.dig_o   <= '0;
      bus.frame_o <= 1'b0;
    end else if (state_q == SHOW) begin
      bus.seg_o   <= cur_blank ? 7'd0 : cur_glyph;
      bus.dp_o    <= active_dp[digit_q];
      bus.dig_o   <= 4'b0001 << digit_q;
      bus.frame_o <= 1'b0;
    end else begin
      bus.seg_o   <= '0;
      bus.dp_o    <= 1'b0;
      bus.dig_o   <= '0;
      bus.frame_o <= (cnt_q == '0) && (digit_q == 2'd0);
    end
  end

  assign bus.scan_state = state_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver with SCAN_DIV = 8, BLANK_CYC = 2.
// A reference model computes, from the cycle number since reset and the
// history of loads, what the display must show; the expected word is
// queued at each rising edge and a monitor compares on the falling edge.
module tb_display_scan_driver;
  import display_scan_driver_pkg::*;

  localparam int D  = 8;
  localparam int B  = 2;
  localparam int FR = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scan_driver_if bus();

  display_scan_driver #(.SCAN_DIV(D), .BLANK_CYC(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // {state, frame, dig[3:0], dp, seg[6:0]}
  logic [13:0] exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          t_now   = 0;

  int          ld_t[$];
  logic [15:0] ld_v[$];
  logic [3:0]  ld_dp[$];

  logic [6:0] glyph_tab [16];
  initial begin
    glyph_tab[0] = 7'h3F; glyph_tab[1] = 7'h06; glyph_tab[2] = 7'h5B;
    glyph_tab[3] = 7'h4F; glyph_tab[4] = 7'h66; glyph_tab[5] = 7'h6D;
    glyph_tab[6] = 7'h7D; glyph_tab[7] = 7'h07; glyph_tab[8] = 7'h7F;
    glyph_tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) glyph_tab[i] = 7'h40;
  end

  // Value shown in frame f: the last load issued before that frame began.
  function automatic void frame_data(input int f, output logic [15:0] v,
                                     output logic [3:0] dpv);
    v = 16'd0;
    dpv = 4'd0;
    for (int i = ld_t.size() - 1; i >= 0; i--) begin
      if (ld_t[i] < f * FR) begin
        v = ld_v[i];
        dpv = ld_dp[i];
        return;
      end
    end
  endfunction

  function automatic logic [13:0] model_out(input int t, input logic lz);
    int          p, d;
    logic [15:0] v;
    logic [3:0]  dpv;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        st, fr, dpo;
    logic [3:0]  dig;
    logic [6:0]  seg;
    p = t % D;
    d = (t / D) % 4;
    frame_data(t / FR, v, dpv);
    st  = (((t + 1) % D) >= B);
    fr  = 1'b0;
    dig = 4'd0;
    dpo = 1'b0;
    seg = 7'd0;
    if (p < B) begin
      fr = (p == 0) && (d == 0);
    end else begin
      dig   = 4'(1 << d);
      upper = v >> (4 * d);
      nib   = upper[3:0];
      dpo   = dpv[d];
      seg   = (lz && d != 0 && upper == 16'd0) ? 7'd0 : glyph_tab[nib];
    end
    return {st, fr, dig, dpo, seg};
  endfunction

  // Reference model: one expected word per rising edge out of reset.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.push_back(model_out(t_now, bus.lz_blank_i));
      if (bus.load_i) begin
        ld_t.push_back(t_now);
        ld_v.push_back(bus.value_i);
        ld_dp.push_back(bus.dp_i);
      end
      t_now++;
    end
  end

  function automatic logic [13:0] observed();
    return {bus.scan_state == SHOW, bus.frame_o, bus.dig_o, bus.dp_o, bus.seg_o};
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [13:0] got, want;
    got = observed();
    if (rst) begin
      vectors++;
      if (got != 14'd0) begin
        errors++;
        $display("FAIL reset_outputs t=%0t got=%h want=0", $time, got);
      end
    end else if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      vectors++;
      if (got != want) begin
        errors++;
        $display("FAIL scan_output cyc=%0d got st=%b fr=%b dig=%b dp=%b seg=%b want st=%b fr=%b dig=%b dp=%b seg=%b",
                 t_now - 1, got[13], got[12], got[11:8], got[7], got[6:0],
                 want[13], want[12], want[11:8], want[7], want[6:0]);
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (at a falling edge) until the next rising edge is cycle m of a frame.
  task automatic wait_for(input int m);
    for (int i = 0; i <= FR; i++) begin
      if (t_now % FR == m) return;
      @(negedge clk);
    end
    errors++;
    $display("FAIL wait_for timeout phase=%0d now=%0d", m, t_now % FR);
  endtask

  task automatic load_now(input logic [15:0] v, input logic [3:0] dpv);
    bus.value_i = v;
    bus.dp_i    = dpv;
    bus.load_i  = 1'b1;
    @(negedge clk);
    bus.load_i  = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    exp_q.delete();
    ld_t.delete();
    ld_v.delete();
    ld_dp.delete();
    t_now = 0;
    #1;
    vectors++;
    if (observed() != 14'd0) begin
      errors++;
      $display("FAIL async_reset got=%h want=0", observed());
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    bus.value_i    = '0;
    bus.load_i     = 1'b0;
    bus.dp_i       = '0;
    bus.lz_blank_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Idle display after reset: zeros on every digit.
    run_cycles(2 * FR);

    // Mid-frame load appears only from the next frame.
    wait_for(10);
    load_now(16'h1234, 4'b0010);
    run_cycles(2 * FR);

    // Leading-zero suppression.
    bus.lz_blank_i = 1'b1;
    wait_for(5);
    load_now(16'h0007, 4'b0000);
    run_cycles(2 * FR);
    bus.lz_blank_i = 1'b0;

    // Last load wins; boundary-cycle load goes straight to the display.
    wait_for(3);
    load_now(16'h1111, 4'b0001);
    wait_for(12);
    load_now(16'h2222, 4'b0100);
    wait_for(FR - 1);
    load_now(16'h3333, 4'b1000);
    run_cycles(2 * FR);

    // Non-BCD code shows a dash.
    wait_for(0);
    load_now(16'h00F0, 4'b0000);
    run_cycles(2 * FR);

    // Reset during a digit-2 SHOW cycle.
    wait_for(2 * D + 4);
    pulse_reset();
    @(negedge clk);
    run_cycles(2 * FR);

    // Random loads, values (including non-BCD), dp and blanking level.
    for (int i = 0; i < 1200; i++) begin
      if (i % 40 == 0) bus.lz_blank_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        bus.value_i = 16'($urandom);
        if ($urandom_range(0, 1) == 0) bus.value_i[15:8] = 8'd0;
        bus.dp_i    = 4'($urandom_range(0, 15));
        bus.load_i  = 1'b1;
      end else begin
        bus.load_i  = 1'b0;
      end
      @(negedge clk);
    end
    bus.load_i = 1'b0;
    run_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit slot; legal range 4..65535.
REQ-002 Parameter BLANK_CYC, default 16: blanking cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 value_i  in  16  four BCD digits from the counter; digit0 = [3:0] (least significant), digit3 = [15:12].
REQ-007 load_i  in  1  one-cycle strobe; captures value_i and dp_i.
REQ-008 dp_i  in  4  decimal-point request per digit, bit n = digit n.
REQ-009 lz_blank_i  in  1  level; 1 = suppress leading zeros.
REQ-010 seg_o  out  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-011 dp_o  out  1  decimal-point segment, active-high.
REQ-012 dig_o  out  4  digit enable, one-hot or zero, active-high.
REQ-013 frame_o  out  1  one-cycle pulse marking the start of a digit-0 slot.

Function
REQ-014 A slot counter shall count 0..SCAN_DIV-1 and wrap; on wrap, the digit index shall advance 0->1->2->3->0.
REQ-015 State machine, two states: BLANK while counter < BLANK_CYC, SHOW otherwise.
REQ-016 In BLANK: dig_o = 0, seg_o = 0, dp_o = 0.
REQ-017 In SHOW: dig_o = one-hot of the digit index; seg_o = decoded active digit; dp_o = active dp bit.
REQ-018 Decode: 0-9 to standard glyphs (0 = 0111111, 1 = 0000110, 8 = 1111111); codes A-F to "-" (1000000).
REQ-019 load_i shall write value_i and dp_i into a shadow register and set a pending flag.
REQ-020 At a frame boundary (digit 3 -> 0 wrap), a pending shadow shall copy into the active register, and pending shall clear.
REQ-021 A load_i in the boundary cycle itself shall go straight to the active register, with pending left clear.
REQ-022 Multiple loads within one frame: the last load wins.
REQ-023 Active data shall never change mid-frame.
REQ-024 With lz_blank_i = 1, digit n (n = 3..1) shall show seg_o = 0 when it and every higher digit are zero; digit 0 is never blanked.
REQ-025 dp_o shall follow dp_i even on a blanked digit.
REQ-026 frame_o shall be high exactly in the first BLANK cycle of each digit-0 slot.
REQ-027 All outputs shall be registered.
REQ-028 Outputs shall appear one cycle after the internal state that produces them.
REQ-029 There shall be no combinational path from input to output.

Reset
REQ-030 While rst is high, all outputs shall be 0.
REQ-031 While rst is high: active = shadow = 0, pending = 0, digit index 0, counter 0, state BLANK.
REQ-032 Reset asserted mid-slot shall clear outputs asynchronously in the same cycle.
REQ-033 After rst deasserts, the first edge shall begin the digit-0 BLANK.
REQ-034 frame_o shall pulse on the following edge.
REQ-035 With no load after reset, the display shall show "0" on digit 0, and on every digit unless blanked.

Structure
REQ-036 A shared package shall hold: the state enum (BLANK, SHOW), NUM_DIGITS = 4, and the glyph constants for 0-9 and dash.
REQ-037 One combinational sub-module, seg7_decode (4-bit in, 7-bit out), shall be instantiated once on the muxed active digit.
REQ-038 Counter width shall be $clog2(SCAN_DIV).
REQ-039 Elaboration shall fail on illegal parameter values.

Verification (SCAN_DIV = 8, BLANK_CYC = 2)
REQ-040 Reset release, no load -> dig_o sequence per slot: 2 cycles 0000 then 6 cycles 0001/0010/0100/1000; seg_o = 0111111 in SHOW; frame_o every 32 cycles.
REQ-041 load value_i = 0x1234, dp_i = 0010, mid-frame -> old value for the rest of the frame; the next frame shows 4,3,2,1 on digits 0-3 with dp on digit 1 only.
REQ-042 load 0x0007 with lz_blank_i = 1 -> digits 3-1 have seg_o = 0 while dig_o still scans; digit 0 shows 0000111.
REQ-043 Two loads 0x1111 then 0x2222 in one frame, plus a load 0x3333 in the boundary cycle -> 0x3333 is displayed in the next frame.
REQ-044 value_i = 0x00F0 -> digit 1 shows 1000000.
REQ-045 rst pulsed during a digit-2 SHOW -> outputs go 0 immediately; the scan restarts at digit 0 with active = 0.
